// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit memory initiator:
//   - funct3 encodings for loads and stores (same encodings the data memory
//     decodes)
//   - FSM state encoding for lsu_mem_master
//   - size decode and legality helpers
// -----------------------------------------------------------------------------
package lsu_pkg;

    // Store encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Load encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ0  = 3'd1,
        ST_WAIT0 = 3'd2,
        ST_REQ1  = 3'd3,
        ST_WAIT1 = 3'd4,
        ST_RESP  = 3'd5
    } lsu_state_e;

    // Access size in bytes; 0 for encodings that carry no size.
    function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
        case (funct3)
            3'b000, 3'b100: return 3'd1;
            3'b001, 3'b101: return 3'd2;
            3'b010:         return 3'd4;
            default:        return 3'd0;
        endcase
    endfunction

    function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
        if (we) begin
            return funct3 inside {F3_SB, F3_SH, F3_SW};
        end
        return funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational lane logic for the load/store unit.
//   funct3_i  : access encoding (size + signedness)
//   offset_i  : byte offset within the word, addr[1:0]
//   wdata_i   : right-aligned store data
//   lo_i/hi_i : beat-0 and beat-1 read words
//   be0_o/be1_o       : byte enables for beat 0 / beat 1
//   wdata0_o/wdata1_o : lane-shifted store data for beat 0 / beat 1
//   split_o   : access crosses a word boundary and needs a second beat
//   ldata_o   : load result, extracted and sign/zero extended
// -----------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] lo_i,
    input  logic [31:0] hi_i,
    output logic [3:0]  be0_o,
    output logic [3:0]  be1_o,
    output logic [31:0] wdata0_o,
    output logic [31:0] wdata1_o,
    output logic        split_o,
    output logic [31:0] ldata_o
);

    logic [2:0]  size;
    logic [3:0]  base_mask;
    logic [7:0]  lane_mask;
    logic [63:0] wdata_shifted;
    logic [31:0] rdata_shifted;

    always_comb begin
        size          = size_bytes(funct3_i);
        // (2^n - 1): size 4 gives 16 - 1 = 4'b1111, which still fits 5 bits.
        base_mask     = 4'((5'd1 << size) - 5'd1);
        lane_mask     = 8'({4'b0000, base_mask} << offset_i);
        wdata_shifted = {32'b0, wdata_i} << {offset_i, 3'b000};
        rdata_shifted = 32'({hi_i, lo_i} >> {offset_i, 3'b000});
        split_o       = ({2'b00, offset_i} + {1'b0, size}) > 4'd4;

        be0_o    = lane_mask[3:0];
        be1_o    = lane_mask[7:4];
        wdata0_o = wdata_shifted[31:0];
        wdata1_o = wdata_shifted[63:32];

        // NOTE: every output of a combinational block needs a value on every
        // path; the default arm here is what keeps ldata_o from becoming a latch.
        case (funct3_i)
            F3_LB:   ldata_o = {{24{rdata_shifted[7]}},  rdata_shifted[7:0]};
            F3_LH:   ldata_o = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            F3_LW:   ldata_o = rdata_shifted;
            F3_LBU:  ldata_o = {24'b0, rdata_shifted[7:0]};
            F3_LHU:  ldata_o = {16'b0, rdata_shifted[15:0]};
            default: ldata_o = 32'b0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// -----------------------------------------------------------------------------
// lsu_mem_master
// Load/store initiator between the MEM stage and the byte-lane data memory.
// Accepts one load/store per req handshake, splits misaligned accesses into
// two word transactions, shifts store data into lanes and extends load data.
//
// Ports
//   clk, rst                      : clock, async active-high reset
//   req_valid/req_ready           : request handshake (ready only in IDLE)
//   req_we, req_funct3, req_addr, req_wdata : request payload
//   rsp_valid                     : one-cycle completion pulse
//   rsp_rdata, rsp_err            : registered result, held until next response
//   mem_req/mem_gnt               : memory request handshake
//   mem_we, mem_addr, mem_be, mem_wdata : memory request payload (0 when idle)
//   mem_rvalid, mem_rdata         : per-transaction read data / write ack
// -----------------------------------------------------------------------------
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(4);

    lsu_state_e        state_q;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       lo_q;

    logic              req_ready_q;
    logic              rsp_valid_q;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [3:0]        mem_be_q;
    logic [31:0]       mem_wdata_q;

    // Lane logic sees the live request in IDLE so beat 0 can be registered
    // on the accept edge; afterwards it works from the captured request.
    logic              is_idle;
    logic [2:0]        al_funct3;
    logic [1:0]        al_offset;
    logic [31:0]       al_wdata;
    logic [31:0]       al_lo;
    logic [3:0]        be0, be1;
    logic [31:0]       wd0, wd1;
    logic              split;
    logic [31:0]       ld_data;
    logic              accept;
    logic [ADDR_W-1:0] beat0_addr_req;
    logic [ADDR_W-1:0] beat1_addr;

    assign is_idle   = (state_q == ST_IDLE);
    assign al_funct3 = is_idle ? req_funct3     : f3_q;
    assign al_offset = is_idle ? req_addr[1:0]  : addr_q[1:0];
    assign al_wdata  = is_idle ? req_wdata      : wdata_q;
    // In WAIT0 the low word is still on the bus; aligned loads finish from it.
    assign al_lo     = (state_q == ST_WAIT0) ? mem_rdata : lo_q;

    assign accept         = req_valid && req_ready_q;
    assign beat0_addr_req = {req_addr[ADDR_W-1:2], 2'b00};
    // Wraps modulo 2^ADDR_W at the top of the address space.
    assign beat1_addr     = {addr_q[ADDR_W-1:2], 2'b00} + WORD_BYTES;

    lsu_align u_align (
        .funct3_i (al_funct3),
        .offset_i (al_offset),
        .wdata_i  (al_wdata),
        .lo_i     (al_lo),
        .hi_i     (mem_rdata),
        .be0_o    (be0),
        .be1_o    (be1),
        .wdata0_o (wd0),
        .wdata1_o (wd1),
        .split_o  (split),
        .ldata_o  (ld_data)
    );

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            addr_q      <= '0;
            wdata_q     <= 32'b0;
            lo_q        <= 32'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'b0;
            rsp_err_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= 32'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        we_q        <= req_we;
                        f3_q        <= req_funct3;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        req_ready_q <= 1'b0;
                        if (funct3_legal(req_we, req_funct3)) begin
                            state_q     <= ST_REQ0;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= req_we;
                            mem_addr_q  <= beat0_addr_req;
                            mem_be_q    <= be0;
                            mem_wdata_q <= req_we ? wd0 : 32'b0;
                        end else begin
                            // Illegal encodings never touch the memory port.
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= 32'b0;
                        end
                    end
                end

                ST_REQ0, ST_REQ1: begin
                    if (mem_gnt) begin
                        state_q     <= (state_q == ST_REQ0) ? ST_WAIT0 : ST_WAIT1;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_be_q    <= 4'b0000;
                        mem_wdata_q <= 32'b0;
                    end
                end

                ST_WAIT0: begin
                    if (mem_rvalid) begin
                        lo_q <= mem_rdata;
                        if (split) begin
                            state_q     <= ST_REQ1;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= we_q;
                            mem_addr_q  <= beat1_addr;
                            mem_be_q    <= be1;
                            mem_wdata_q <= we_q ? wd1 : 32'b0;
                        end else begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b0;
                            rsp_rdata_q <= we_q ? 32'b0 : ld_data;
                        end
                    end
                end

                ST_WAIT1: begin
                    if (mem_rvalid) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= we_q ? 32'b0 : ld_data;
                    end
                end

                ST_RESP: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                end

                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                    mem_req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// -----------------------------------------------------------------------------
// tb_lsu_mem_master
// Directed vectors with hand-computed expectations. Stimulus pushes expected
// memory beats and responses into queues; a memory responder and a response
// monitor pop and compare whenever the DUT presents a beat or a response.
// -----------------------------------------------------------------------------
module tb_lsu_mem_master;

    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010,
                           LBU = 3'b100, LHU = 3'b101;
    localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'b0;
    logic [31:0] req_wdata = 32'b0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    lsu_mem_master #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          t_acc;
    } rsp_t;

    beat_t exp_beats[$];
    rsp_t  exp_rsp[$];
    logic [31:0] mem [logic [31:0]];

    int n_cmp  = 0;
    int n_fail = 0;
    int gnt_delay = 0;
    int rv_delay  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'b0;
    endfunction

    task automatic mem_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        logic [31:0] w;
        w = mem_read(a);
        for (int b = 0; b < 4; b++)
            if (be[b]) w[8*b +: 8] = d[8*b +: 8];
        mem[a] = w;
    endtask

    task automatic push_beat(input logic we, input logic [31:0] a, input logic [3:0] be,
                             input logic [31:0] d);
        beat_t b;
        b.we = we; b.addr = a; b.be = be; b.wdata = d;
        exp_beats.push_back(b);
    endtask

    // Called at a negedge; returns at the negedge after the accept cycle.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic has_rsp,
                         input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        rsp_t r;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
        for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
        if (!req_ready) begin
            check("accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        if (has_rsp) begin
            r.rdata = exp_rdata; r.err = exp_err; r.lat = exp_lat; r.t_acc = cyc;
            exp_rsp.push_back(r);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100; i++) begin
            if (exp_rsp.size() == 0 && exp_beats.size() == 0) break;
            @(negedge clk);
        end
        if (exp_rsp.size() != 0 || exp_beats.size() != 0) begin
            check("drain_timeout", 32'(exp_rsp.size() + exp_beats.size()), 32'd0);
            exp_rsp.delete();
            exp_beats.delete();
        end
    endtask

    task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_rdata,
                       input logic exp_err, input int exp_lat);
        issue(we, f3, a, d, 1'b1, exp_rdata, exp_err, exp_lat);
        wait_done();
    endtask

    // Response monitor
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                if (exp_rsp.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got rsp_valid with rdata %h err %0b, required none (cycle %0d)",
                             rsp_rdata, rsp_err, cyc);
                end else begin
                    e = exp_rsp.pop_front();
                    check("rsp_rdata",   rsp_rdata, e.rdata);
                    check("rsp_err",     32'(rsp_err), 32'(e.err));
                    check("rsp_latency", 32'(cyc - e.t_acc), 32'(e.lat));
                end
            end
        end
    end

    // Memory responder: checks each beat, applies grant / rvalid delays.
    initial begin
        beat_t b, e;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h5A5A5A5A;
        forever begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h5A5A5A5A;
            if (mem_req && !rst) begin
                b.we = mem_we; b.addr = mem_addr; b.be = mem_be; b.wdata = mem_wdata;
                if (exp_beats.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got we %0b addr %h be %b wdata %h, required none (cycle %0d)",
                             b.we, b.addr, b.be, b.wdata, cyc);
                end else begin
                    e = exp_beats.pop_front();
                    check("beat_we",    32'(b.we), 32'(e.we));
                    check("beat_addr",  b.addr, e.addr);
                    check("beat_be",    32'(b.be), 32'(e.be));
                    check("beat_wdata", b.wdata, e.wdata);
                end
                for (int i = 0; i < gnt_delay; i++) begin
                    mem_gnt = 1'b0;
                    @(negedge clk);
                    check("stall_req",   32'(mem_req), 32'd1);
                    check("stall_addr",  mem_addr, b.addr);
                    check("stall_be",    32'(mem_be), 32'(b.be));
                    check("stall_wdata", mem_wdata, b.wdata);
                    check("stall_ready", 32'(req_ready), 32'd0);
                end
                mem_gnt = 1'b1;
                @(negedge clk);
                mem_gnt = 1'b0;
                check("post_gnt_req",  32'(mem_req), 32'd0);
                check("post_gnt_addr", mem_addr, 32'd0);
                check("post_gnt_be",   32'(mem_be), 32'd0);
                for (int i = 0; i < rv_delay; i++) @(negedge clk);
                mem_rvalid = 1'b1;
                if (b.we) mem_write(b.addr, b.be, b.wdata);
                else      mem_rdata = mem_read(b.addr);
            end
        end
    end

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err",   32'(rsp_err), 32'd0);
        check("rst_mem_req",   32'(mem_req), 32'd0);
        check("rst_mem_we",    32'(mem_we), 32'd0);
        check("rst_mem_addr",  mem_addr, 32'd0);
        check("rst_mem_be",    32'(mem_be), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);

        // Aligned store
        push_beat(1'b1, 32'h100, 4'b1111, 32'hDEADBEEF);
        run(1'b1, SW, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 3);

        // Byte loads at the top lane
        mem[32'h100] = 32'h80000000;
        push_beat(1'b0, 32'h100, 4'b1000, 32'h0);
        run(1'b0, LB, 32'h103, 32'h0, 32'hFFFFFF80, 1'b0, 3);
        repeat (3) @(negedge clk);
        check("rsp_rdata_hold", rsp_rdata, 32'hFFFFFF80);
        check("rsp_valid_pulse", 32'(rsp_valid), 32'd0);
        push_beat(1'b0, 32'h100, 4'b1000, 32'h0);
        run(1'b0, LBU, 32'h103, 32'h0, 32'h00000080, 1'b0, 3);

        // Split word load
        mem[32'h100] = 32'h44332211;
        mem[32'h104] = 32'h88776655;
        push_beat(1'b0, 32'h100, 4'b1100, 32'h0);
        push_beat(1'b0, 32'h104, 4'b0011, 32'h0);
        run(1'b0, LW, 32'h102, 32'h0, 32'h66554433, 1'b0, 5);

        // Split halfword store, then read it back both ways
        push_beat(1'b1, 32'h1FC, 4'b1000, 32'hCD000000);
        push_beat(1'b1, 32'h200, 4'b0001, 32'h000000AB);
        run(1'b1, SH, 32'h1FF, 32'h0000ABCD, 32'h0, 1'b0, 5);
        push_beat(1'b0, 32'h1FC, 4'b1000, 32'h0);
        push_beat(1'b0, 32'h200, 4'b0001, 32'h0);
        run(1'b0, LHU, 32'h1FF, 32'h0, 32'h0000ABCD, 1'b0, 5);
        push_beat(1'b0, 32'h1FC, 4'b1000, 32'h0);
        push_beat(1'b0, 32'h200, 4'b0001, 32'h0);
        run(1'b0, LH, 32'h1FF, 32'h0, 32'hFFFFABCD, 1'b0, 5);

        // Split store wrapping past the top of the address space
        push_beat(1'b1, 32'hFFFFFFFC, 4'b1000, 32'h34000000);
        push_beat(1'b1, 32'h00000000, 4'b0001, 32'h00000012);
        run(1'b1, SH, 32'hFFFFFFFF, 32'h00001234, 32'h0, 1'b0, 5);

        // Delayed rvalid (two extra cycles)
        rv_delay = 2;
        push_beat(1'b0, 32'h100, 4'b0010, 32'h0);
        run(1'b0, LBU, 32'h101, 32'h0, 32'h00000022, 1'b0, 5);
        push_beat(1'b0, 32'h100, 4'b1100, 32'h0);
        run(1'b0, LH, 32'h102, 32'h0, 32'h00004433, 1'b0, 5);
        rv_delay = 0;

        // Aligned negative halfword
        mem[32'h108] = 32'h00008001;
        push_beat(1'b0, 32'h108, 4'b0011, 32'h0);
        run(1'b0, LH, 32'h108, 32'h0, 32'hFFFF8001, 1'b0, 3);

        // Backpressure: grant withheld for 3 cycles, a second request waits
        gnt_delay = 3;
        push_beat(1'b0, 32'h104, 4'b1111, 32'h0);
        issue(1'b0, LW, 32'h104, 32'h0, 1'b1, 32'h88776655, 1'b0, 6);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = SW;
        req_addr = 32'h300; req_wdata = 32'h11112222;
        for (int i = 0; i < 3; i++) begin
            check("bp_ready_low", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        wait_done();
        gnt_delay = 0;

        // Illegal encodings: no memory traffic, immediate error response
        run(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1, 1);
        run(1'b0, 3'b111, 32'h100, 32'h0, 32'h0, 1'b1, 1);
        run(1'b1, 3'b100, 32'h100, 32'h12345678, 32'h0, 1'b1, 1);
        run(1'b1, 3'b011, 32'h100, 32'h12345678, 32'h0, 1'b1, 1);

        // Leave a nonzero result registered so the reset is visible
        push_beat(1'b0, 32'h104, 4'b1111, 32'h0);
        run(1'b0, LW, 32'h104, 32'h0, 32'h88776655, 1'b0, 3);

        // Reset while waiting for rvalid; the late rvalid must be ignored
        rv_delay = 4;
        push_beat(1'b0, 32'h104, 4'b1111, 32'h0);
        issue(1'b0, LW, 32'h104, 32'h0, 1'b0, 32'h0, 1'b0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_mem_req",   32'(mem_req), 32'd0);
        check("rst_mid_ready",     32'(req_ready), 32'd1);
        check("rst_mid_rsp_rdata", rsp_rdata, 32'd0);
        repeat (6) @(negedge clk);
        check("late_rvalid_no_rsp", 32'(rsp_valid), 32'd0);
        check("late_rvalid_no_req", 32'(mem_req), 32'd0);
        rv_delay = 0;

        // Recovery after reset
        push_beat(1'b1, 32'h10C, 4'b0100, 32'h00EE0000);
        run(1'b1, SB, 32'h10E, 32'h000000EE, 32'h0, 1'b0, 3);
        push_beat(1'b0, 32'h10C, 4'b0100, 32'h0);
        run(1'b0, LB, 32'h10E, 32'h0, 32'hFFFFFFEE, 1'b0, 3);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
